// File: rtl/simon_button_ctrl.sv
// simon_button_ctrl: synchronises and debounces the Simon buttons and turns accepted presses into gated stack strobes.
module simon_button_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int DATA_WIDTH      = 2,
  parameter int NUM_BTN         = 2**DATA_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [NUM_BTN-1:0]    BTN,
  input  logic                  BTN_POP,
  input  logic                  FULL,
  input  logic                  EMPTY,
  output logic                  PUSH,
  output logic                  POP,
  output logic [DATA_WIDTH-1:0] DATA_OUT,
  output logic                  ERR,
  output logic [3:0]            ERR_CNT
);
  localparam int N = NUM_BTN + 1;
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);
  typedef enum logic {IDLE, HELD} state_t;
  state_t state, state_n;
  logic [N-1:0] s1, s2, db, db_q;
  logic [CW-1:0] cnt [N];
  logic [NUM_BTN-1:0] col;
  logic [DATA_WIDTH-1:0] code;
  logic rise, eval, push_n, pop_n, err_n;
  // Bit 0 of every press vector is the pop button; bits above it are the colours.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      s1 <= '0;
      s2 <= '0;
      db <= '0;
      db_q <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      s1 <= {BTN, BTN_POP};
      s2 <= s1;
      db_q <= db;
      for (int i = 0; i < N; i++)
        if (s2[i] == db[i]) cnt[i] <= '0;
        else if (cnt[i] == CMAX) begin
          cnt[i] <= '0;
          db[i] <= s2[i];
        end else cnt[i] <= cnt[i] + 1'b1;
    end
  end
  assign col = db[N-1:1];
  assign rise = |(db & ~db_q);
  always_comb begin
    code = '0;
    for (int i = 0; i < NUM_BTN; i++) if (col[i]) code = DATA_WIDTH'(i);
  end
  always_ff @(posedge CLK) state <= !RST_N ? IDLE : state_n;
  always_comb state_n = (state == IDLE) ? (rise ? HELD : IDLE) : ((db == '0) ? IDLE : HELD);
  // Every evaluated press produces exactly one of PUSH, POP or ERR.
  always_comb begin
    eval = (state == IDLE) && rise;
    push_n = eval && $onehot(db) && !db[0] && !FULL;
    pop_n = eval && (db == N'(1)) && !EMPTY;
    err_n = eval && !push_n && !pop_n;
  end
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      PUSH <= 1'b0;
      POP <= 1'b0;
      ERR <= 1'b0;
      DATA_OUT <= '0;
      ERR_CNT <= '0;
    end else begin
      PUSH <= push_n;
      POP <= pop_n;
      ERR <= err_n;
      if (push_n) DATA_OUT <= code;
      if (err_n && ERR_CNT != 4'hf) ERR_CNT <= ERR_CNT + 1'b1;
    end
  end
endmodule

// File: tb/tb_simon_button_ctrl.sv
// tb_simon_button_ctrl: directed test-plan scenarios plus random presses checked each cycle against a behavioural model.
module tb_simon_button_ctrl;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [3:0] btn = '0;
  logic btn_pop = 1'b0, full = 1'b0, empty = 1'b0;
  logic push, pop, err;
  logic [1:0] data_out;
  logic [3:0] err_cnt;
  int total = 0, bad = 0;
  int n_push = 0, n_pop = 0, n_err = 0;
  simon_button_ctrl #(.DEBOUNCE_CYCLES(D), .DATA_WIDTH(2), .NUM_BTN(4)) dut (
    .CLK(clk), .RST_N(rst_n), .BTN(btn), .BTN_POP(btn_pop), .FULL(full), .EMPTY(empty),
    .PUSH(push), .POP(pop), .DATA_OUT(data_out), .ERR(err), .ERR_CNT(err_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask
  // Reference model: a debounced bit flips once the last D synchronised samples all disagree with it.
  logic [4:0] hist[$];
  logic [4:0] m_db, m_dbp, m_rise;
  bit m_held, m_valid = 0, all_diff;
  logic m_push, m_pop, m_err;
  logic [1:0] m_data;
  int m_cnt;
  always @(posedge clk) begin
    if (!rst_n) begin
      hist = {};
      for (int i = 0; i < D + 2; i++) hist.push_back(5'b0);
      m_db = '0; m_dbp = '0; m_held = 0;
      m_push = 0; m_pop = 0; m_err = 0; m_data = '0; m_cnt = 0; m_valid = 1;
    end else begin
      m_rise = m_db & ~m_dbp;
      m_push = 0; m_pop = 0; m_err = 0;
      if (!m_held && m_rise != 0) begin
        if ($countones(m_db) != 1) m_err = 1;
        else if (m_db[0]) begin
          if (empty) m_err = 1; else m_pop = 1;
        end else if (full) m_err = 1;
        else begin
          m_push = 1;
          for (int k = 0; k < 4; k++) if (m_db[k+1]) m_data = 2'(k);
        end
        m_held = 1;
      end else if (m_held && m_db == 0) m_held = 0;
      if (m_err && m_cnt < 15) m_cnt++;
      m_dbp = m_db;
      for (int b = 0; b < 5; b++) begin
        all_diff = 1;
        for (int j = 0; j < D; j++) if (hist[hist.size()-2-j][b] == m_db[b]) all_diff = 0;
        if (all_diff) m_db[b] = ~m_db[b];
      end
      hist.push_back({btn, btn_pop});
      if (hist.size() > D + 2) void'(hist.pop_front());
    end
  end
  always @(negedge clk) begin
    if (m_valid) begin
      chk("push", 32'(push), 32'(m_push));
      chk("pop", 32'(pop), 32'(m_pop));
      chk("err", 32'(err), 32'(m_err));
      chk("data_out", 32'(data_out), 32'(m_data));
      chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
    end
    if (push === 1'b1) n_push++;
    if (pop === 1'b1) n_pop++;
    if (err === 1'b1) n_err++;
  end
  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic run_until(input int lim, output int n);
    n = -1;
    for (int i = 1; i <= lim; i++) begin
      @(negedge clk);
      #1;
      if (push || pop || err) begin
        n = i;
        break;
      end
    end
  endtask
  int n, p, e0, sel, hold;
  logic [4:0] v;
  initial begin
    step(3);
    rst_n = 1'b1;
    step(1);
    chk("rst_push", 32'(push), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_cnt", 32'(err_cnt), 0);
    btn = 4'b0100;
    p = n_push;
    run_until(20, n);
    chk("push_latency", n, 7);
    chk("push_data2", 32'(data_out), 2);
    step(20);
    chk("no_repeat", n_push - p, 1);
    btn = '0;
    step(12);
    p = n_push;
    repeat (3) begin
      btn = 4'b0010; step(3);
      btn = '0; step(1);
    end
    btn = 4'b0010;
    run_until(20, n);
    chk("bounce_latency", n, 7);
    chk("bounce_data1", 32'(data_out), 1);
    step(10);
    chk("bounce_one_push", n_push - p, 1);
    btn = '0;
    step(12);
    full = 1'b1;
    btn = 4'b1000;
    run_until(20, n);
    chk("full_err_lat", n, 7);
    chk("full_err", 32'(err), 1);
    chk("full_no_push", 32'(push), 0);
    chk("full_data_kept", 32'(data_out), 1);
    chk("full_cnt1", 32'(err_cnt), 1);
    step(1);
    chk("err_one_cycle", 32'(err), 0);
    btn = '0;
    step(12);
    full = 1'b0;
    empty = 1'b1;
    btn_pop = 1'b1;
    run_until(20, n);
    chk("empty_err", 32'(err), 1);
    chk("empty_no_pop", 32'(pop), 0);
    chk("empty_cnt2", 32'(err_cnt), 2);
    btn_pop = 1'b0;
    step(12);
    empty = 1'b0;
    btn_pop = 1'b1;
    run_until(20, n);
    chk("pop_latency", n, 7);
    chk("pop_strobe", 32'(pop), 1);
    step(1);
    chk("pop_one_cycle", 32'(pop), 0);
    btn_pop = 1'b0;
    step(12);
    btn = 4'b0001;
    btn_pop = 1'b1;
    run_until(20, n);
    chk("combo_err", 32'(err), 1);
    chk("combo_no_push", 32'(push), 0);
    btn_pop = 1'b0;
    btn = 4'b0101;
    p = n_push + n_pop + n_err;
    step(20);
    chk("held_ignored", n_push + n_pop + n_err - p, 0);
    btn = '0;
    step(12);
    btn = 4'b0100;
    run_until(20, n);
    chk("after_release_push", 32'(push), 1);
    chk("after_release_data", 32'(data_out), 2);
    btn = '0;
    step(12);
    full = 1'b1;
    e0 = n_err;
    repeat (14) begin
      btn = 4'b1000; step(10);
      btn = '0; step(12);
    end
    chk("err_count_14", n_err - e0, 14);
    chk("err_cnt_sat", 32'(err_cnt), 15);
    full = 1'b0;
    btn = 4'b0010;
    step(3);
    rst_n = 1'b0;
    step(1);
    chk("midrst_cnt", 32'(err_cnt), 0);
    chk("midrst_data", 32'(data_out), 0);
    chk("midrst_strobes", 32'({push, pop, err}), 0);
    btn = '0;
    step(1);
    rst_n = 1'b1;
    p = n_push + n_pop + n_err;
    step(20);
    chk("midrst_no_strobe", n_push + n_pop + n_err - p, 0);
    btn = 4'b0010;
    step(3);
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    run_until(20, n);
    chk("held_rst_latency", n, 7);
    chk("held_rst_data", 32'(data_out), 1);
    btn = '0;
    step(12);
    p = n_push;
    for (int s = 0; s < 500; s++) begin
      sel = $urandom_range(0, 9);
      v = (sel < 4) ? 5'b0 : (sel < 8) ? 5'(1 << $urandom_range(0, 4)) : 5'($urandom_range(0, 31));
      {btn, btn_pop} = v;
      full = ($urandom_range(0, 3) == 0);
      empty = ($urandom_range(0, 3) == 0);
      rst_n = ($urandom_range(0, 79) != 0);
      hold = $urandom_range(1, 10);
      step(hold);
      rst_n = 1'b1;
    end
    btn = '0;
    btn_pop = 1'b0;
    step(12);
    chk("rnd_push_seen", 32'(n_push > p), 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
